sdo_frame_deserializer: RTL and testbench

- Downstream stage of the serial shift-register transmitter. It consumes the transmitter's serial output (SDO_signal_out) one bit per enabled clock.
- It hunts for a sync pattern, then assembles a fixed number of MSB-first payload words per frame.
- Each word is presented on a single-entry valid/ready output to the word-processing logic. Overruns are flagged rather than stalling the serial link, since the transmitter cannot be back-pressured.

---
 rtl/sdo_frame_deserializer_pkg.sv | 14 +
 rtl/sdo_out_reg.sv | 65 ++++++
 rtl/sdo_frame_deserializer.sv | 108 ++++++++++
 tb/tb_sdo_frame_deserializer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/sdo_frame_deserializer_pkg.sv
// Shared constants for the SDO serial link: FSM encoding and the framing
// defaults that the transmitter and this deserializer must agree on.
`timescale 1ns/1ps
package sdo_frame_deserializer_pkg;

  localparam logic [0:0] ST_HUNT    = 1'b0;
  localparam logic [0:0] ST_PAYLOAD = 1'b1;

  localparam int                    SDO_WORD_W          = 16;
  localparam int                    SDO_SYNC_W          = 8;
  localparam logic [SDO_SYNC_W-1:0] SDO_SYNC_PATTERN    = 8'hA5;
  localparam int                    SDO_WORDS_PER_FRAME = 4;

endpackage

// File: rtl/sdo_out_reg.sv
// Single-entry valid/ready holding register. A word that arrives while the
// entry is full and not being drained is dropped and flagged as a sticky overrun.
`timescale 1ns/1ps
module sdo_out_reg
  import sdo_frame_deserializer_pkg::*;
#(
  parameter int WORD_W = SDO_WORD_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_wr,
  input  logic [WORD_W-1:0] i_data,
  input  logic              i_last,
  input  logic              i_ready,
  input  logic              i_clr_overrun,
  output logic [WORD_W-1:0] o_data,
  output logic              o_valid,
  output logic              o_last,
  output logic              o_overrun
);

  logic [WORD_W-1:0] r_data;
  logic              r_valid;
  logic              r_last;
  logic              r_overrun;
  logic              w_handshake;
  logic              w_load;
  logic              w_drop;

  assign w_handshake = r_valid & i_ready;
  assign w_load      = i_wr & (~r_valid | w_handshake);
  assign w_drop      = i_wr & r_valid & ~i_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else if (w_load) begin
      r_data  <= i_data;
      r_valid <= 1'b1;
      r_last  <= i_last;
    end else if (w_handshake) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end
  end

  // A fresh drop wins over a clear requested in the same cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_overrun <= 1'b0;
    end else if (w_drop) begin
      r_overrun <= 1'b1;
    end else if (i_clr_overrun) begin
      r_overrun <= 1'b0;
    end
  end

  assign o_data    = r_data;
  assign o_valid   = r_valid;
  assign o_last    = r_last;
  assign o_overrun = r_overrun;

endmodule

// File: rtl/sdo_frame_deserializer.sv
// Hunts for the sync pattern on the serial line, then assembles a fixed number
// of MSB-first payload words per frame and hands them to the output register.
`timescale 1ns/1ps
module sdo_frame_deserializer
  import sdo_frame_deserializer_pkg::*;
#(
  parameter int                WORD_W          = SDO_WORD_W,
  parameter int                SYNC_W          = SDO_SYNC_W,
  parameter logic [SYNC_W-1:0] SYNC_PATTERN    = SDO_SYNC_PATTERN,
  parameter int                WORDS_PER_FRAME = SDO_WORDS_PER_FRAME
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_sdi,
  input  logic              i_sdi_en,
  output logic [WORD_W-1:0] o_word_data,
  output logic              o_word_valid,
  input  logic              i_word_ready,
  output logic              o_word_last,
  output logic              o_frame_lock,
  output logic              o_overrun,
  input  logic              i_clr_overrun
);

  localparam int BIT_CW  = $clog2(WORD_W);
  localparam int WORD_CW = (WORDS_PER_FRAME > 1) ? $clog2(WORDS_PER_FRAME) : 1;
  localparam int FILL_CW = $clog2(SYNC_W + 1);

  logic [0:0]        r_state;
  logic [SYNC_W-1:0] r_window;
  logic [FILL_CW-1:0] r_fill;
  logic [BIT_CW-1:0] r_bit_cnt;
  logic [WORD_CW-1:0] r_word_cnt;
  logic [WORD_W-1:0] r_shift;

  logic [SYNC_W-1:0]  w_window_next;
  logic [FILL_CW-1:0] w_fill_next;
  logic [WORD_W-1:0]  w_shift_next;
  logic               w_sync_hit;
  logic               w_bit_term;
  logic               w_word_term;
  logic               w_word_done;

  assign w_window_next = {r_window[SYNC_W-2:0], i_sdi};
  assign w_fill_next   = (r_fill == FILL_CW'(SYNC_W)) ? r_fill : r_fill + 1'b1;
  // Only a completely filled window may match, so reset zeros never alias.
  assign w_sync_hit    = (w_fill_next == FILL_CW'(SYNC_W)) && (w_window_next == SYNC_PATTERN);
  assign w_shift_next  = {r_shift[WORD_W-2:0], i_sdi};
  assign w_bit_term    = (r_bit_cnt == BIT_CW'(WORD_W - 1));
  assign w_word_term   = (r_word_cnt == WORD_CW'(WORDS_PER_FRAME - 1));
  assign w_word_done   = (r_state == ST_PAYLOAD) && i_sdi_en && w_bit_term;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_HUNT;
      r_window   <= '0;
      r_fill     <= '0;
      r_bit_cnt  <= '0;
      r_word_cnt <= '0;
      r_shift    <= '0;
    end else if (i_sdi_en) begin
      if (r_state == ST_HUNT) begin
        r_window <= w_window_next;
        r_fill   <= w_fill_next;
        if (w_sync_hit) begin
          r_state    <= ST_PAYLOAD;
          r_bit_cnt  <= '0;
          r_word_cnt <= '0;
        end
      end else begin
        r_shift <= w_shift_next;
        if (w_bit_term) begin
          r_bit_cnt <= '0;
          // Last payload bit ends the frame; the next bit starts a fresh sync search.
          if (w_word_term) begin
            r_word_cnt <= '0;
            r_state    <= ST_HUNT;
            r_window   <= '0;
            r_fill     <= '0;
          end else begin
            r_word_cnt <= r_word_cnt + 1'b1;
          end
        end else begin
          r_bit_cnt <= r_bit_cnt + 1'b1;
        end
      end
    end
  end

  assign o_frame_lock = (r_state == ST_PAYLOAD);

  sdo_out_reg #(
    .WORD_W (WORD_W)
  ) u_out_reg (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_wr          (w_word_done),
    .i_data        (w_shift_next),
    .i_last        (w_word_term),
    .i_ready       (i_word_ready),
    .i_clr_overrun (i_clr_overrun),
    .o_data        (o_word_data),
    .o_valid       (o_word_valid),
    .o_last        (o_word_last),
    .o_overrun     (o_overrun)
  );

endmodule

// File: tb/tb_sdo_frame_deserializer.sv
// Scoreboard bench for sdo_frame_deserializer: expected words are queued as
// frames are driven and popped whenever the output handshakes.
`timescale 1ns/1ps
module tb_sdo_frame_deserializer;
  import sdo_frame_deserializer_pkg::*;

  typedef struct packed {
    logic [15:0] data;
    logic        last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic        sdi = 1'b0;
  logic        sdiEn = 1'b0;
  logic        wordReady = 1'b0;
  logic        clrOverrun = 1'b0;
  logic [15:0] wordData;
  logic        wordValid;
  logic        wordLast;
  logic        frameLock;
  logic        overrun;

  exp_t        sbQ[$];
  exp_t        monExp;
  logic [15:0] frameWords [4];
  int          checks = 0;
  int          fails = 0;

  sdo_frame_deserializer dut (
    .i_clk         (clk),
    .i_rst_n       (rstN),
    .i_sdi         (sdi),
    .i_sdi_en      (sdiEn),
    .o_word_data   (wordData),
    .o_word_valid  (wordValid),
    .i_word_ready  (wordReady),
    .o_word_last   (wordLast),
    .o_frame_lock  (frameLock),
    .o_overrun     (overrun),
    .i_clr_overrun (clrOverrun)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Handshake is seen on the falling edge; the word leaves on the next rising edge.
  always @(negedge clk) begin
    if (rstN && wordValid && wordReady) begin
      if (sbQ.size() == 0) begin
        checkOutput("sb_unexpected_word", 32'(sbQ.size()), 32'd1);
      end else begin
        monExp = sbQ.pop_front();
        checkOutput("word_data", {16'h0, wordData}, {16'h0, monExp.data});
        checkOutput("word_last", {31'h0, wordLast}, {31'h0, monExp.last});
      end
    end
  end

  // Caller sits at rising edge + 1; returns at the next rising edge + 1.
  task automatic sendBit(input logic b, input logic en);
    sdi   = b;
    sdiEn = en;
    @(posedge clk);
    #1;
  endtask

  task automatic sendBits(input logic [15:0] v, input int n, input logic half);
    for (int i = n - 1; i >= 0; i--) begin
      if (half) sendBit(1'($urandom), 1'b0);
      sendBit(v[i], 1'b1);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) sendBit(1'($urandom), 1'b0);
  endtask

  task automatic pushWord(input logic [15:0] d, input logic l);
    exp_t e;
    e.data = d;
    e.last = l;
    sbQ.push_back(e);
  endtask

  task automatic pushFrame();
    for (int w = 0; w < 4; w++) pushWord(frameWords[w], (w == 3));
  endtask

  task automatic sendFrameWords(input logic half, input logic chkValid);
    for (int w = 0; w < 4; w++) begin
      sendBits(frameWords[w], 16, half);
      if (chkValid) checkOutput("valid_latency", {31'h0, wordValid}, 32'd1);
    end
    checkOutput("lock_drop_after_frame", {31'h0, frameLock}, 32'd0);
    sdiEn = 1'b0;
  endtask

  task automatic applyStimulus(input logic half);
    sendBits(16'(SDO_SYNC_PATTERN), 8, half);
    checkOutput("lock_after_sync", {31'h0, frameLock}, 32'd1);
    sendFrameWords(half, 1'b1);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_valid"},   {31'h0, wordValid}, 32'd0);
    checkOutput({tag, "_lock"},    {31'h0, frameLock}, 32'd0);
    checkOutput({tag, "_data"},    {16'h0, wordData},  32'd0);
    checkOutput({tag, "_last"},    {31'h0, wordLast},  32'd0);
    checkOutput({tag, "_overrun"}, {31'h0, overrun},   32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    frameWords[0] = 16'h1234;
    frameWords[1] = 16'h5678;
    frameWords[2] = 16'h9ABC;
    frameWords[3] = 16'hDEF0;

    #120;
    checkResetOutputs("reset");
    rstN = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] full-rate frame, consumer always ready");
    wordReady = 1'b1;
    pushFrame();
    applyStimulus(1'b0);
    idle(3);
    checkOutput("t1_overrun", {31'h0, overrun}, 32'd0);
    checkOutput("t1_sb_empty", 32'(sbQ.size()), 32'd0);

    $display("[TB] noise and false sync before the real pattern");
    pushFrame();
    sendBits(16'h003C, 8, 1'b0);
    sendBits(16'h00A4, 8, 1'b0);
    checkOutput("t2_no_lock_after_a4", {31'h0, frameLock}, 32'd0);
    sendBits(16'h0052, 7, 1'b0);
    checkOutput("t2_no_lock_before_match", {31'h0, frameLock}, 32'd0);
    sendBit(1'b1, 1'b1);
    checkOutput("t2_lock_after_match", {31'h0, frameLock}, 32'd1);
    sendFrameWords(1'b0, 1'b1);
    idle(3);
    checkOutput("t2_sb_empty", 32'(sbQ.size()), 32'd0);

    $display("[TB] consumer stalled for a whole frame");
    wordReady = 1'b0;
    pushWord(16'h1234, 1'b0);
    sendBits(16'h00A5, 8, 1'b0);
    sendBits(16'h1234, 16, 1'b0);
    checkOutput("t3_valid_first", {31'h0, wordValid}, 32'd1);
    checkOutput("t3_no_overrun_yet", {31'h0, overrun}, 32'd0);
    sendBits(16'h5678, 16, 1'b0);
    checkOutput("t3_overrun_set", {31'h0, overrun}, 32'd1);
    sendBits(16'h9ABC, 16, 1'b0);
    sendBits(16'h6F78, 15, 1'b0);
    clrOverrun = 1'b1;
    sendBit(1'b0, 1'b1);
    clrOverrun = 1'b0;
    checkOutput("t3_set_beats_clear", {31'h0, overrun}, 32'd1);
    checkOutput("t3_held_data", {16'h0, wordData}, 32'h1234);
    checkOutput("t3_held_last", {31'h0, wordLast}, 32'd0);
    clrOverrun = 1'b1;
    sendBit(1'b0, 1'b0);
    clrOverrun = 1'b0;
    checkOutput("t3_overrun_cleared", {31'h0, overrun}, 32'd0);
    wordReady = 1'b1;
    idle(3);
    checkOutput("t3_valid_drained", {31'h0, wordValid}, 32'd0);
    checkOutput("t3_sb_empty", 32'(sbQ.size()), 32'd0);

    $display("[TB] ready rises on the cycle the next word completes");
    wordReady = 1'b0;
    pushFrame();
    sendBits(16'h00A5, 8, 1'b0);
    sendBits(16'h1234, 16, 1'b0);
    sendBits(16'h2B3C, 15, 1'b0);
    checkOutput("t4_valid_before", {31'h0, wordValid}, 32'd1);
    wordReady = 1'b1;
    sendBit(1'b0, 1'b1);
    checkOutput("t4_valid_no_bubble", {31'h0, wordValid}, 32'd1);
    checkOutput("t4_new_data", {16'h0, wordData}, 32'h5678);
    sendBits(16'h9ABC, 16, 1'b0);
    sendBits(16'hDEF0, 16, 1'b0);
    sdiEn = 1'b0;
    idle(3);
    checkOutput("t4_overrun", {31'h0, overrun}, 32'd0);
    checkOutput("t4_sb_empty", 32'(sbQ.size()), 32'd0);

    $display("[TB] half-rate bit strobe");
    wordReady = 1'b1;
    pushFrame();
    applyStimulus(1'b1);
    idle(3);
    checkOutput("t5_sb_empty", 32'(sbQ.size()), 32'd0);

    $display("[TB] asynchronous reset mid-frame");
    wordReady = 1'b0;
    sendBits(16'h00A5, 8, 1'b0);
    sendBits(16'h1234, 16, 1'b0);
    sendBits(16'h0056, 8, 1'b0);
    checkOutput("t6_valid_before_reset", {31'h0, wordValid}, 32'd1);
    #2;
    rstN = 1'b0;
    #1;
    checkResetOutputs("t6_async");
    #20;
    rstN = 1'b1;
    @(posedge clk);
    #1;
    wordReady = 1'b1;
    pushFrame();
    applyStimulus(1'b0);
    idle(3);
    checkOutput("t6_sb_empty", 32'(sbQ.size()), 32'd0);
    checkOutput("t6_overrun", {31'h0, overrun}, 32'd0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
